// File: rtl/uart_pkg.sv
// Shared encodings for the host-side UART bridge: FSM states, error-bit layout
// and the RX FIFO entry format.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_HOLD,
      S_RD,
      S_GAP
   } state_t;

   localparam int ERR_PARITY  = 0;
   localparam int ERR_FRAMING = 1;
   localparam int ERR_OVERRUN = 2;

   localparam int GAP_DEFAULT = 3;

   typedef struct packed {
      logic [2:0] err;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_host_bridge_if.sv
// Host-facing valid/ready streams of the bridge: TX bytes in, RX bytes plus
// error flags out.
interface uart_host_bridge_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic [2:0] rx_err;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_err, rx_valid
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_err, rx_valid
   );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; head reads as zero while empty so the
// outputs are clean straight out of reset.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_wvalid,
   output logic             o_wready,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_rvalid,
   input  logic             i_rready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_wready = (r_count != FULL_CNT);
   assign o_rvalid = (r_count != '0);
   assign w_push   = i_wvalid && o_wready;
   assign w_pop    = i_rready && o_rvalid;
   assign o_rdata  = o_rvalid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/uart_host_bridge.sv
// Bridge between host valid/ready streams and the UART core's strobe/bidir bus.
// One access at a time; each access is followed by a settle gap.
module uart_host_bridge
   import uart_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int WR_PULSE = 4,
   parameter int RD_PULSE = 4,
   parameter int GAP      = GAP_DEFAULT
) (
   input  logic             clkx16,
   input  logic             reset_n,
   uart_host_bridge_if.slave bus,
   output logic             uart_write,
   output logic             uart_read,
   inout  wire  [7:0]       uart_data,
   input  logic             uart_txrdy,
   input  logic             uart_rxrdy,
   input  logic             uart_parityerr,
   input  logic             uart_framingerr,
   input  logic             uart_overrun
);

   localparam int MAXP = (WR_PULSE > RD_PULSE) ? ((WR_PULSE > GAP) ? WR_PULSE : GAP)
                                               : ((RD_PULSE > GAP) ? RD_PULSE : GAP);
   localparam int CW = $clog2(MAXP + 1);
   localparam logic [CW-1:0] WR_LAST  = CW'(WR_PULSE - 1);
   localparam logic [CW-1:0] RD_LAST  = CW'(RD_PULSE - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_last_tx;
   logic [2:0]    r_err;
   logic [7:0]    r_bus_q;
   logic          r_bus_en;
   logic          r_write;
   logic          r_read;

   logic [7:0]    w_tx_head;
   logic          w_tx_avail;
   logic          w_tx_pop;
   logic          w_rx_room;
   logic          w_rx_push;
   rx_entry_t     w_rx_in;
   rx_entry_t     w_rx_out;
   logic          w_tx_req;
   logic          w_rx_req;
   logic          w_grant_rx;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk      (clkx16),
      .rst_n    (reset_n),
      .i_wdata  (bus.tx_data),
      .i_wvalid (bus.tx_valid),
      .o_wready (bus.tx_ready),
      .o_rdata  (w_tx_head),
      .o_rvalid (w_tx_avail),
      .i_rready (w_tx_pop)
   );

   sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(DEPTH)) u_rx_fifo (
      .clk      (clkx16),
      .rst_n    (reset_n),
      .i_wdata  (w_rx_in),
      .i_wvalid (w_rx_push),
      .o_wready (w_rx_room),
      .o_rdata  (w_rx_out),
      .o_rvalid (bus.rx_valid),
      .i_rready (bus.rx_ready)
   );

   assign bus.rx_data = w_rx_out.data;
   assign bus.rx_err  = w_rx_out.err;

   assign uart_write = r_write;
   assign uart_read  = r_read;
   assign uart_data  = r_bus_en ? r_bus_q : 8'bz;

   assign w_tx_req   = w_tx_avail && uart_txrdy;
   assign w_rx_req   = w_rx_room && uart_rxrdy;
   // RX wins a tie only if TX was serviced last; r_last_tx resets to 1.
   assign w_grant_rx = w_rx_req && (!w_tx_req || r_last_tx);

   assign w_tx_pop   = (r_state == S_WR) && (r_cnt == WR_LAST);
   assign w_rx_push  = (r_state == S_RD) && (r_cnt == RD_LAST);
   assign w_rx_in    = '{err: r_err, data: uart_data};

   always_ff @(posedge clkx16 or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_last_tx <= 1'b1;
         r_err     <= '0;
         r_bus_q   <= '0;
         r_bus_en  <= 1'b0;
         r_write   <= 1'b0;
         r_read    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_grant_rx) begin
                  r_state   <= S_RD;
                  r_read    <= 1'b1;
                  r_last_tx <= 1'b0;
                  // UART clears its flags shortly after read rises, so grab them now.
                  r_err[ERR_PARITY]  <= uart_parityerr;
                  r_err[ERR_FRAMING] <= uart_framingerr;
                  r_err[ERR_OVERRUN] <= uart_overrun;
               end else if (w_tx_req) begin
                  r_state   <= S_WR;
                  r_write   <= 1'b1;
                  r_bus_en  <= 1'b1;
                  r_bus_q   <= w_tx_head;
                  r_last_tx <= 1'b1;
               end
            end
            S_WR: begin
               if (r_cnt == WR_LAST) begin
                  r_state <= S_WR_HOLD;
                  r_write <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_WR_HOLD: begin
               r_state  <= S_GAP;
               r_bus_en <= 1'b0;
            end
            S_RD: begin
               if (r_cnt == RD_LAST) begin
                  r_state <= S_GAP;
                  r_read  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
